// File: rtl/memory_game_ctrl.sv
// Memory-match game controller: cursor movement over a 4x4 grid, two-card
// reveal sequencing, match compare, mismatch hold timer and win handling.
module memory_game_ctrl #(
    parameter int HOLD_CYCLES = 12500000,
    parameter int HOLD_W      = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic [63:0] pos_flat,
    output logic [15:0] regCard,
    output logic [3:0]  cursor,
    output logic [7:0]  moves,
    output logic [3:0]  pairs,
    output logic        busy,
    output logic        win
);

    // state    | meaning
    // PICK1    | waiting for the first card of a pair
    // PICK2    | waiting for the second card of a pair
    // CHECK    | one cycle: compare the two revealed symbols
    // HOLD     | mismatch visible, hold counter running down
    // WIN      | all pairs found, every card shown
    typedef enum logic [2:0] {
        ST_PICK1,
        ST_PICK2,
        ST_CHECK,
        ST_HOLD,
        ST_WIN
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [15:0]       reg_card_q, reg_card_d;
    logic [3:0]        cursor_q, cursor_d;
    logic [7:0]        moves_q, moves_d;
    logic [3:0]        pairs_q, pairs_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        first_q, first_d;
    logic [3:0]        second_q, second_d;
    logic              busy_q, win_q;

    logic [1:0] row, col;
    logic       sel_ok;
    logic [3:0] sym_a, sym_b;

    always_comb begin
        state_d    = state_q;
        reg_card_d = reg_card_q;
        cursor_d   = cursor_q;
        moves_d    = moves_q;
        pairs_d    = pairs_q;
        hold_d     = hold_q;
        first_d    = first_q;
        second_d   = second_q;

        row    = cursor_q[3:2];
        col    = cursor_q[1:0];
        sel_ok = btn_sel && !reg_card_q[cursor_q];
        sym_a  = pos_flat[{first_q, 2'b00} +: 4];
        sym_b  = pos_flat[{second_q, 2'b00} +: 4];

        if (state_q != ST_WIN) begin
            if (btn_up)         cursor_d = {row - 2'd1, col};
            else if (btn_down)  cursor_d = {row + 2'd1, col};
            else if (btn_left)  cursor_d = {row, col - 2'd1};
            else if (btn_right) cursor_d = {row, col + 2'd1};
        end

        case (state_q)
            ST_PICK1: begin
                if (sel_ok) begin
                    reg_card_d[cursor_q] = 1'b1;
                    first_d              = cursor_q;
                    state_d              = ST_PICK2;
                end
            end
            ST_PICK2: begin
                if (sel_ok) begin
                    reg_card_d[cursor_q] = 1'b1;
                    second_d             = cursor_q;
                    if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
                    state_d              = ST_CHECK;
                end
            end
            ST_CHECK: begin
                // Symbols 2k and 2k+1 form a pair, so only the upper bits matter.
                if (sym_a[3:1] == sym_b[3:1]) begin
                    pairs_d = pairs_q + 4'd1;
                    state_d = (pairs_q == 4'd7) ? ST_WIN : ST_PICK1;
                end else begin
                    hold_d  = HOLD_LOAD;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_q == '0) begin
                    reg_card_d[first_q]  = 1'b0;
                    reg_card_d[second_q] = 1'b0;
                    state_d              = ST_PICK1;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            ST_WIN: begin
                reg_card_d = 16'hFFFF;
                if (btn_sel) begin
                    reg_card_d = '0;
                    moves_d    = '0;
                    pairs_d    = '0;
                    cursor_d   = '0;
                    state_d    = ST_PICK1;
                end
            end
            default: state_d = ST_PICK1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_PICK1;
            reg_card_q <= '0;
            cursor_q   <= '0;
            moves_q    <= '0;
            pairs_q    <= '0;
            hold_q     <= '0;
            first_q    <= '0;
            second_q   <= '0;
            busy_q     <= 1'b0;
            win_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_card_q <= reg_card_d;
            cursor_q   <= cursor_d;
            moves_q    <= moves_d;
            pairs_q    <= pairs_d;
            hold_q     <= hold_d;
            first_q    <= first_d;
            second_q   <= second_d;
            busy_q     <= (state_d == ST_CHECK) || (state_d == ST_HOLD);
            win_q      <= (state_d == ST_WIN);
        end
    end

    assign regCard = reg_card_q;
    assign cursor  = cursor_q;
    assign moves   = moves_q;
    assign pairs   = pairs_q;
    assign busy    = busy_q;
    assign win     = win_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Testbench for memory_game_ctrl: directed scenarios plus randomized button
// traffic checked against an event-level game model.
module tb_memory_game_ctrl;

    localparam int HC = 4;
    localparam int HW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        b_up = 0, b_down = 0, b_left = 0, b_right = 0, b_sel = 0;
    logic [63:0] pos_flat = '0;
    logic [15:0] regCard;
    logic [3:0]  cursor;
    logic [7:0]  moves;
    logic [3:0]  pairs;
    logic        busy;
    logic        win;

    int total = 0;
    int bad   = 0;

    memory_game_ctrl #(.HOLD_CYCLES(HC), .HOLD_W(HW)) dut (
        .clk(clk), .rst(rst),
        .btn_up(b_up), .btn_down(b_down), .btn_left(b_left), .btn_right(b_right),
        .btn_sel(b_sel), .pos_flat(pos_flat),
        .regCard(regCard), .cursor(cursor), .moves(moves), .pairs(pairs),
        .busy(busy), .win(win)
    );

    always #5 clk = ~clk;

    // Game model: picked cards queue, a pending-compare flag and a countdown
    // until a mismatched pair is hidden again.
    logic [15:0] m_mask;
    int          m_cur, m_moves, m_pairs, m_hide;
    bit          m_won, m_cmp;
    int          m_picks[$];

    function automatic int sym(input int c);
        return int'(pos_flat[4*c +: 4]);
    endfunction

    function automatic bit m_busy();
        return m_cmp || (m_hide > 0);
    endfunction

    task automatic model_reset();
        m_mask = '0; m_cur = 0; m_moves = 0; m_pairs = 0; m_hide = 0;
        m_won = 0; m_cmp = 0;
        m_picks.delete();
    endtask

    task automatic model_step();
        int r, c, cur0;
        cur0 = m_cur;
        if (m_won) begin
            m_mask = 16'hFFFF;
            if (b_sel) begin
                m_mask = '0; m_moves = 0; m_pairs = 0; m_cur = 0; m_won = 0;
            end
            return;
        end
        r = m_cur / 4;
        c = m_cur % 4;
        if (b_up)         r = (r + 3) % 4;
        else if (b_down)  r = (r + 1) % 4;
        else if (b_left)  c = (c + 3) % 4;
        else if (b_right) c = (c + 1) % 4;
        m_cur = r * 4 + c;
        if (m_cmp) begin
            m_cmp = 0;
            if (sym(m_picks[0]) / 2 == sym(m_picks[1]) / 2) begin
                m_pairs++;
                m_picks.delete();
                if (m_pairs == 8) m_won = 1;
            end else begin
                m_hide = HC;
            end
        end else if (m_hide > 0) begin
            m_hide--;
            if (m_hide == 0) begin
                m_mask[m_picks[0]] = 1'b0;
                m_mask[m_picks[1]] = 1'b0;
                m_picks.delete();
            end
        end else if (b_sel && !m_mask[cur0]) begin
            m_mask[cur0] = 1'b1;
            m_picks.push_back(cur0);
            if (m_picks.size() == 2) begin
                if (m_moves < 255) m_moves++;
                m_cmp = 1;
            end
        end
    endtask

    task automatic tick(input bit u, input bit d, input bit l, input bit r, input bit s);
        b_up = u; b_down = d; b_left = l; b_right = r; b_sel = s;
        @(posedge clk);
        model_step();
        #1;
        b_up = 0; b_down = 0; b_left = 0; b_right = 0; b_sel = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0);
    endtask

    task automatic goto_card(input int target);
        for (int k = 0; k < 8 && m_cur != target; k++) begin
            if (m_cur / 4 != target / 4) tick(0, 1, 0, 0, 0);
            else                         tick(0, 0, 0, 1, 0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic shuffle_symbols();
        int perm[16];
        for (int i = 0; i < 16; i++) perm[i] = i;
        for (int i = 15; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 16; i++) pos_flat[4*i +: 4] = 4'(perm[i]);
    endtask

    task automatic test_reset();
        pos_flat = '0;
        pos_flat[3:0] = 4'd3;
        pos_flat[7:4] = 4'd15;
        do_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        idle(2);
        total++;
        if (regCard !== 16'h0003 || busy !== 1'b1) begin
            bad++; $display("FAIL reset_prehold regCard=%h busy=%b want 0003/1", regCard, busy);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({regCard, cursor, moves, pairs, busy, win} !== 34'd0) begin
            bad++;
            $display("FAIL reset_async regCard=%h cursor=%0d moves=%0d pairs=%0d busy=%b win=%b want all 0",
                     regCard, cursor, moves, pairs, busy, win);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(0, 0, 0, 0, 1);
        total++;
        if (regCard !== 16'h0001 || busy !== 1'b0) begin
            bad++; $display("FAIL reset_pick1 regCard=%h busy=%b want 0001/0", regCard, busy);
        end
    endtask

    task automatic test_cursor_wrap();
        int exp_c[5] = '{3, 15, 3, 0, 12};
        bit [3:0] btn[5] = '{4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b1010};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick(btn[i][3], btn[i][2], btn[i][1], btn[i][0], 0);
            total++;
            if (cursor !== 4'(exp_c[i])) begin
                bad++; $display("FAIL cursor_wrap step=%0d cursor=%0d want %0d", i, cursor, exp_c[i]);
            end
        end
    endtask

    task automatic test_match();
        do_reset();
        pos_flat = 64'hFEDC_BA98_7654_5410;
        pos_flat[3:0]   = 4'd3;
        pos_flat[51:48] = 4'd2;
        tick(0, 0, 0, 0, 1);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        total++;
        if (regCard !== 16'h1001 || moves !== 8'd1 || pairs !== 4'd0) begin
            bad++; $display("FAIL match_reveal regCard=%h moves=%0d pairs=%0d want 1001/1/0", regCard, moves, pairs);
        end
        idle(1);
        total++;
        if (pairs !== 4'd1 || busy !== 1'b0 || regCard !== 16'h1001) begin
            bad++; $display("FAIL match_keep pairs=%0d busy=%b regCard=%h want 1/0/1001", pairs, busy, regCard);
        end
    endtask

    task automatic test_mismatch();
        int n;
        do_reset();
        pos_flat = '0;
        pos_flat[3:0] = 4'd3;
        pos_flat[7:4] = 4'd15;
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy) break;
            n++;
            total++;
            if (regCard !== 16'h0003) begin
                bad++; $display("FAIL mismatch_visible cycle=%0d regCard=%h want 0003", n, regCard);
            end
            tick(0, 0, 0, n == 1, 1);
        end
        total++;
        if (n !== HC + 1) begin
            bad++; $display("FAIL mismatch_busy_len got=%0d want %0d", n, HC + 1);
        end
        total++;
        if (regCard !== 16'h0000 || moves !== 8'd1 || pairs !== 4'd0) begin
            bad++; $display("FAIL mismatch_hide regCard=%h moves=%0d pairs=%0d want 0000/1/0", regCard, moves, pairs);
        end
    endtask

    task automatic test_reselect();
        do_reset();
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        total++;
        if (regCard !== 16'h0001 || moves !== 8'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL reselect_ignored regCard=%h moves=%0d busy=%b want 0001/0/0", regCard, moves, busy);
        end
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1);
        total++;
        if (busy !== 1'b1 || moves !== 8'd1 || regCard !== 16'h0003) begin
            bad++; $display("FAIL reselect_pick2 busy=%b moves=%0d regCard=%h want 1/1/0003", busy, moves, regCard);
        end
        idle(HC + 2);
    endtask

    task automatic test_full_game();
        int a, b;
        logic [3:0] cur_win;
        do_reset();
        shuffle_symbols();
        for (int k = 0; k < 8; k++) begin
            a = 0; b = 0;
            for (int i = 0; i < 16; i++) begin
                if (sym(i) == 2*k)     a = i;
                if (sym(i) == 2*k + 1) b = i;
            end
            goto_card(a);
            tick(0, 0, 0, 0, 1);
            goto_card(b);
            tick(0, 0, 0, 0, 1);
            idle(1);
        end
        total++;
        if (pairs !== 4'd8 || win !== 1'b1 || regCard !== 16'hFFFF || moves !== 8'd8 || busy !== 1'b0) begin
            bad++;
            $display("FAIL game_win pairs=%0d win=%b regCard=%h moves=%0d busy=%b want 8/1/ffff/8/0",
                     pairs, win, regCard, moves, busy);
        end
        cur_win = cursor;
        tick(0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 0);
        total++;
        if (cursor !== cur_win || win !== 1'b1) begin
            bad++; $display("FAIL win_cursor_frozen cursor=%0d win=%b want %0d/1", cursor, win, cur_win);
        end
        tick(0, 0, 0, 0, 1);
        total++;
        if ({regCard, cursor, moves, pairs, busy, win} !== 34'd0) begin
            bad++;
            $display("FAIL win_restart regCard=%h cursor=%0d moves=%0d pairs=%0d busy=%b win=%b want all 0",
                     regCard, cursor, moves, pairs, busy, win);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        pos_flat = '0;
        pos_flat[3:0] = 4'd0;
        pos_flat[7:4] = 4'd2;
        for (int i = 0; i < 256; i++) begin
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 0, 1, 0);
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 1, 0, 0);
            for (int w = 0; w < 12 && busy; w++) idle(1);
            if (i == 254) begin
                total++;
                if (moves !== 8'd255) begin
                    bad++; $display("FAIL moves_reach_255 moves=%0d want 255", moves);
                end
            end
        end
        total++;
        if (moves !== 8'd255 || pairs !== 4'd0 || regCard !== 16'h0000) begin
            bad++; $display("FAIL moves_saturate moves=%0d pairs=%0d regCard=%h want 255/0/0000", moves, pairs, regCard);
        end
    endtask

    task automatic test_random();
        logic [33:0] exp_v, got_v;
        do_reset();
        shuffle_symbols();
        for (int i = 0; i < 4000; i++) begin
            tick($urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(5, 0) == 0,
                 $urandom_range(4, 0) == 0, $urandom_range(2, 0) == 0);
            exp_v = {m_mask, 4'(m_cur), 8'(m_moves), 4'(m_pairs), m_busy(), m_won};
            got_v = {regCard, cursor, moves, pairs, busy, win};
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL random cycle=%0d got=%h want=%h", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        model_reset();
        #12;
        test_reset();
        test_cursor_wrap();
        test_match();
        test_mismatch();
        test_reselect();
        test_full_game();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
